// File: rtl/cmd_queue_irq_coalesce.sv
// Per-source (SQ/CQ) interrupt coalescing with count threshold and timeout, issuing one
// vectored request at a time over req/ack. Optional statistics: CMD_QUEUE_IRQ_COALESCE_STATS_EN.
module cmd_queue_irq_coalesce #(
  parameter int unsigned C_CNT_WIDTH = 8,
  parameter int unsigned C_TMR_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   irq_sq_in,
  input  logic                   irq_cq_in,
  input  logic                   cfg_enable,
  input  logic [C_CNT_WIDTH-1:0] cfg_threshold,
  input  logic [C_TMR_WIDTH-1:0] cfg_timeout,
  output logic                   irq_req,
  output logic                   irq_vec,
  input  logic                   irq_ack,
  output logic [C_CNT_WIDTH-1:0] sq_pending,
  output logic [C_CNT_WIDTH-1:0] cq_pending
`ifdef CMD_QUEUE_IRQ_COALESCE_STATS_EN
  ,
  input  logic                   stat_clr,
  output logic [31:0]            stat_sq_sent,
  output logic [31:0]            stat_cq_sent
`endif
);

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [C_CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [C_TMR_WIDTH-1:0] TMR_ONE = {{(C_TMR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [C_TMR_WIDTH-1:0] TMR_MAX = '1;

  state_t                 state;
  logic                   rr;
  logic [1:0]             irq_in;
  logic [1:0]             irq_q;
  logic [1:0]             evt;
  logic [1:0]             ready;
  logic [1:0]             ready_q;
  logic [1:0]             granted;
  logic [1:0]             clr;
  logic                   ack_take;
  logic                   gnt_sel;
  logic [C_CNT_WIDTH-1:0] thr_eff;
  logic [C_CNT_WIDTH-1:0] cnt [2];
  logic [C_TMR_WIDTH-1:0] tmr [2];

  // Index 0 is SQ, index 1 is CQ, matching the irq_vec encoding.
  assign irq_in     = {irq_cq_in, irq_sq_in};
  assign evt        = irq_in & ~irq_q;
  assign sq_pending = cnt[0];
  assign cq_pending = cnt[1];
  assign thr_eff    = (cfg_threshold == '0) ? CNT_ONE : cfg_threshold;
  assign ack_take   = (state == ST_REQ) && irq_ack;
  assign granted    = (state == ST_REQ) ? {irq_vec, ~irq_vec} : 2'b00;
  assign clr        = ack_take ? granted : 2'b00;
  assign gnt_sel    = (ready_q == 2'b11) ? rr : ready_q[1];

  always_comb begin
    ready = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      ready[i] = (cnt[i] != '0) &&
                 ((cnt[i] >= thr_eff) || ((cfg_timeout != '0) && (tmr[i] >= cfg_timeout)));
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      irq_q <= '0;
    end else begin
      irq_q <= irq_in;
    end
  end

  // ready_q of a just-acked source is dropped so a stale value cannot re-grant an emptied counter.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ready_q <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        cnt[i] <= '0;
        tmr[i] <= '0;
      end
    end else begin
      ready_q <= ready & ~clr;
      for (int unsigned i = 0; i < 2; i++) begin
        if (clr[i]) begin
          cnt[i] <= evt[i] ? CNT_ONE : '0;
        end else if (evt[i] && (cnt[i] != CNT_MAX)) begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end

        if (clr[i] || (cnt[i] == '0)) begin
          tmr[i] <= '0;
        end else if (!granted[i] && (tmr[i] != TMR_MAX)) begin
          tmr[i] <= tmr[i] + TMR_ONE;
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state   <= ST_IDLE;
      irq_req <= 1'b0;
      irq_vec <= 1'b0;
      rr      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_enable && (ready_q != 2'b00)) begin
            state   <= ST_REQ;
            irq_req <= 1'b1;
            irq_vec <= gnt_sel;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            state   <= ST_IDLE;
            irq_req <= 1'b0;
            rr      <= ~irq_vec;
          end
        end
        default: begin
          state   <= ST_IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef CMD_QUEUE_IRQ_COALESCE_STATS_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stat_sq_sent <= '0;
      stat_cq_sent <= '0;
    end else if (stat_clr) begin
      stat_sq_sent <= '0;
      stat_cq_sent <= '0;
    end else if (ack_take) begin
      if (irq_vec) begin
        stat_cq_sent <= stat_cq_sent + 32'd1;
      end else begin
        stat_sq_sent <= stat_sq_sent + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cmd_queue_irq_coalesce.sv
// Directed-vector bench for cmd_queue_irq_coalesce: per-cycle table plus hand-written
// sequences for timeout, saturation, ack/event collision and async reset.
module tb_cmd_queue_irq_coalesce;

  logic        aclk = 1'b0;
  logic        areset;
  logic        irq_sq_in, irq_cq_in, cfg_enable, irq_ack;
  logic [7:0]  cfg_threshold;
  logic [15:0] cfg_timeout;
  logic        irq_req, irq_vec;
  logic [7:0]  sq_pending, cq_pending;
`ifdef CMD_QUEUE_IRQ_COALESCE_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_sq_sent, stat_cq_sent;
`endif

  int passed = 0;
  int total  = 0;

  always #5 aclk = ~aclk;

  cmd_queue_irq_coalesce #(.C_CNT_WIDTH(8), .C_TMR_WIDTH(16)) dut (
    .aclk(aclk), .areset(areset),
    .irq_sq_in(irq_sq_in), .irq_cq_in(irq_cq_in),
    .cfg_enable(cfg_enable), .cfg_threshold(cfg_threshold), .cfg_timeout(cfg_timeout),
    .irq_req(irq_req), .irq_vec(irq_vec), .irq_ack(irq_ack),
    .sq_pending(sq_pending), .cq_pending(cq_pending)
`ifdef CMD_QUEUE_IRQ_COALESCE_STATS_EN
    , .stat_clr(stat_clr), .stat_sq_sent(stat_sq_sent), .stat_cq_sent(stat_cq_sent)
`endif
  );

  typedef struct {
    logic       sq, cq, ack, en;
    logic [7:0] thr;
    logic [15:0] tmo;
    logic       req, vec;
    logic [7:0] sp, cp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic sq, input logic cq, input logic ack, input logic en,
                     input logic [7:0] thr, input logic [15:0] tmo,
                     input logic req, input logic vec, input logic [7:0] sp, input logic [7:0] cp);
    vec_t v;
    v.sq = sq; v.cq = cq; v.ack = ack; v.en = en; v.thr = thr; v.tmo = tmo;
    v.req = req; v.vec = vec; v.sp = sp; v.cp = cp;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int  k;
    logic seen, stable;

    areset = 1'b1; irq_sq_in = 0; irq_cq_in = 0; irq_ack = 0;
    cfg_enable = 1; cfg_threshold = 8'd1; cfg_timeout = 16'd0;
`ifdef CMD_QUEUE_IRQ_COALESCE_STATS_EN
    stat_clr = 0;
`endif
    repeat (2) tick();
    chk("reset_req", irq_req, 0);
    chk("reset_vec", irq_vec, 0);
    chk("reset_sq_pending", sq_pending, 0);
    chk("reset_cq_pending", cq_pending, 0);
    areset = 1'b0;
    tick();

    // single SQ pulse, thr=1: req two edges after pulse, held 3 cycles
    add(1,0,0,1,1,0, 0,0,1,0);
    add(0,0,0,1,1,0, 0,0,1,0);
    add(0,0,0,1,1,0, 1,0,1,0);
    add(0,0,0,1,1,0, 1,0,1,0);
    add(0,0,0,1,1,0, 1,0,1,0);
    add(0,0,1,1,1,0, 0,0,0,0);
    add(0,0,0,1,1,0, 0,0,0,0);
    // thr=4 on CQ; ack while idle ignored
    add(0,1,0,1,4,0, 0,0,0,1);
    add(0,0,1,1,4,0, 0,0,0,1);
    add(0,1,0,1,4,0, 0,0,0,2);
    add(0,0,0,1,4,0, 0,0,0,2);
    add(0,1,0,1,4,0, 0,0,0,3);
    add(0,0,0,1,4,0, 0,0,0,3);
    add(0,1,0,1,4,0, 0,0,0,4);
    add(0,0,0,1,4,0, 0,0,0,4);
    add(0,0,0,1,4,0, 1,1,0,4);
    add(0,0,0,1,4,0, 1,1,0,4);
    add(0,0,1,1,4,0, 0,0,0,0);
    add(0,0,0,1,4,0, 0,0,0,0);
    // simultaneous SQ+CQ with rr pointing at SQ
    add(1,1,0,1,1,0, 0,0,1,1);
    add(0,0,0,1,1,0, 0,0,1,1);
    add(0,0,0,1,1,0, 1,0,1,1);
    add(0,0,1,1,1,0, 0,0,0,1);
    add(0,0,0,1,1,0, 1,1,0,1);
    add(0,0,1,1,1,0, 0,0,0,0);
    add(0,0,0,1,1,0, 0,0,0,0);
    // thr=0 behaves as 1; after an SQ grant, a simultaneous pair goes CQ first
    add(1,0,0,1,0,0, 0,0,1,0);
    add(0,0,0,1,0,0, 0,0,1,0);
    add(0,0,0,1,0,0, 1,0,1,0);
    add(0,0,1,1,0,0, 0,0,0,0);
    add(1,1,0,1,0,0, 0,0,1,1);
    add(0,0,0,1,0,0, 0,0,1,1);
    add(0,0,0,1,0,0, 1,1,1,1);
    add(0,0,1,1,0,0, 0,0,1,0);
    add(0,0,0,1,0,0, 1,0,1,0);
    add(0,0,1,1,0,0, 0,0,0,0);
    add(0,0,0,1,0,0, 0,0,0,0);

    foreach (tbl[i]) begin
      irq_sq_in = tbl[i].sq; irq_cq_in = tbl[i].cq; irq_ack = tbl[i].ack;
      cfg_enable = tbl[i].en; cfg_threshold = tbl[i].thr; cfg_timeout = tbl[i].tmo;
      tick();
      chk($sformatf("vec%0d_req", i), irq_req, tbl[i].req);
      if (tbl[i].req) chk($sformatf("vec%0d_vec", i), irq_vec, tbl[i].vec);
      chk($sformatf("vec%0d_sq_pending", i), sq_pending, tbl[i].sp);
      chk($sformatf("vec%0d_cq_pending", i), cq_pending, tbl[i].cp);
    end
    irq_ack = 0;

    // timeout: thr=8, tmo=20, fires on the 22nd edge after the pulse edge
    cfg_threshold = 8'd8; cfg_timeout = 16'd20;
    irq_sq_in = 1; tick(); irq_sq_in = 0;
    k = 1;
    while (k <= 40) begin
      tick();
      if (irq_req) break;
      k++;
    end
    chk("tmo_fire_cycle", k, 22);
    chk("tmo_vec", irq_vec, 0);
    irq_ack = 1; tick(); irq_ack = 0;
    chk("tmo_ack_req", irq_req, 0);
    chk("tmo_ack_pending", sq_pending, 0);

    // timeout disabled: never fires
    cfg_timeout = 16'd0;
    irq_sq_in = 1; tick(); irq_sq_in = 0;
    seen = 0;
    repeat (60) begin tick(); seen |= irq_req; end
    chk("notmo_no_req", seen, 0);
    chk("notmo_pending", sq_pending, 1);
    cfg_threshold = 8'd1;
    tick(); tick();
    chk("thr_drop_req", irq_req, 1);
    irq_ack = 1; tick(); irq_ack = 0;
    chk("thr_drop_ack", sq_pending, 0);

    // saturation under held request with enable low
    irq_sq_in = 1; tick(); irq_sq_in = 0; tick(); tick();
    chk("sat_req", irq_req, 1);
    cfg_enable = 0;
    stable = 1;
    repeat (300) begin
      irq_sq_in = 1; tick(); stable &= irq_req & ~irq_vec;
      irq_sq_in = 0; tick(); stable &= irq_req & ~irq_vec;
    end
    chk("sat_stable", stable, 1);
    chk("sat_pending", sq_pending, 255);
    irq_sq_in = 1; irq_ack = 1; tick(); irq_sq_in = 0; irq_ack = 0;
    chk("collide_req", irq_req, 0);
    chk("collide_pending", sq_pending, 1);
    seen = 0;
    repeat (3) begin tick(); seen |= irq_req; end
    chk("disabled_no_req", seen, 0);
    cfg_enable = 1; tick();
    chk("reenable_req", irq_req, 1);
    chk("reenable_vec", irq_vec, 0);
    irq_ack = 1; tick(); irq_ack = 0;
    chk("reenable_ack", sq_pending, 0);

    // async reset mid-request
    irq_sq_in = 1; irq_cq_in = 1; tick(); irq_sq_in = 0; irq_cq_in = 0; tick(); tick();
    chk("rst_pre_req", irq_req, 1);
    #2 areset = 1;
    #1;
    chk("rst_async_req", irq_req, 0);
    chk("rst_async_sq", sq_pending, 0);
    chk("rst_async_cq", cq_pending, 0);
    tick();
    areset = 0;
    tick();
    chk("rst_after_req", irq_req, 0);

`ifdef CMD_QUEUE_IRQ_COALESCE_STATS_EN
    chk("stat_rst_sq", stat_sq_sent, 0);
    chk("stat_rst_cq", stat_cq_sent, 0);
    irq_sq_in = 1; tick(); irq_sq_in = 0; tick(); tick();
    chk("stat_req1", irq_req, 1);
    irq_ack = 1; stat_clr = 1; tick(); irq_ack = 0; stat_clr = 0;
    chk("stat_clr_prio", stat_sq_sent, 0);
    irq_sq_in = 1; tick(); irq_sq_in = 0; tick(); tick();
    irq_ack = 1; tick(); irq_ack = 0;
    chk("stat_sq_inc", stat_sq_sent, 1);
    chk("stat_cq_same", stat_cq_sent, 0);
    stat_clr = 1; tick(); stat_clr = 0;
    chk("stat_clr", stat_sq_sent, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
